// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an asynchronous FIFO: owns the write pointer, exports it in
// Gray code to the read domain, and derives full/level/almost_full from the synchronized
// read pointer. Overflow is a sticky error flag for writes attempted while full.
module fifo_wr_ctrl #(
  parameter int unsigned AddrWidth        = 4,
  parameter int unsigned AlmostFullThresh = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic                 mem_we,
  output logic [AddrWidth-1:0] mem_waddr,
  output logic [AddrWidth:0]   wr_ptr_gray,
  input  logic [AddrWidth:0]   rd_ptr_gray_sync,
  output logic                 full,
  output logic                 almost_full,
  output logic [AddrWidth:0]   level,
  output logic                 overflow,
  input  logic                 overflow_clr
);

  localparam int unsigned PtrW = AddrWidth + 1;

  logic [AddrWidth:0] wbin_q, wbin_d;
  logic [AddrWidth:0] gray_q, gray_d;
  logic [AddrWidth:0] level_q, level_d;
  logic [AddrWidth:0] rbin;
  logic [AddrWidth:0] full_cmp;
  logic               full_q, full_d;
  logic               almost_full_q, almost_full_d;
  logic               overflow_q, overflow_d;
  logic               accept;

  // Next-state: pointer advance, Gray conversion both ways, and flag/level derivation.
  always_comb begin
    accept = wr_valid && !full_q;
    wbin_d = wbin_q + PtrW'(accept);
    gray_d = wbin_d ^ (wbin_d >> 1);

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    rbin = '0;
    for (int i = 0; i < PtrW; i++) begin
      rbin[i] = ^(rd_ptr_gray_sync >> i);
    end

    // Full when the write pointer has lapped the read pointer by exactly one depth:
    // in Gray code that is the read pointer with its top two bits inverted.
    full_cmp      = {~rd_ptr_gray_sync[AddrWidth:AddrWidth-1],
                     rd_ptr_gray_sync[AddrWidth-2:0]};
    full_d        = (gray_d == full_cmp);
    level_d       = wbin_d - rbin;
    almost_full_d = (level_d >= PtrW'(AlmostFullThresh));

    // Set has priority over clear so a coincident error is never lost.
    overflow_d = overflow_q;
    if (overflow_clr) begin
      overflow_d = 1'b0;
    end
    if (wr_valid && full_q) begin
      overflow_d = 1'b1;
    end
  end

  // State registers; every output flag comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q        <= '0;
      gray_q        <= '0;
      level_q       <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wbin_q        <= wbin_d;
      gray_q        <= gray_d;
      level_q       <= level_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  // Output drive: write strobe/address are combinational on the accept cycle.
  always_comb begin
    wr_ready    = !full_q;
    mem_we      = accept;
    mem_waddr   = wbin_q[AddrWidth-1:0];
    wr_ptr_gray = gray_q;
    full        = full_q;
    almost_full = almost_full_q;
    level       = level_q;
    overflow    = overflow_q;
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl (AddrWidth=4, AlmostFullThresh=12). Stimulus queues the
// expected output snapshot for a cycle; a monitor pops and compares it on the falling edge.
module tb_fifo_wr_ctrl;

  logic       clk;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [4:0] wr_ptr_gray;
  logic [4:0] rd_ptr_gray_sync;
  logic       full;
  logic       almost_full;
  logic [4:0] level;
  logic       overflow;
  logic       overflow_clr;

  typedef struct packed {
    logic       rdy;
    logic       we;
    logic [3:0] waddr;
    logic [4:0] gray;
    logic       full;
    logic       af;
    logic [4:0] lvl;
    logic       ovf;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    checks;
  int    passes;

  logic [4:0] wb;
  logic [4:0] rb;
  logic [4:0] lv;

  fifo_wr_ctrl #(
    .AddrWidth        (4),
    .AlmostFullThresh (12)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .mem_we           (mem_we),
    .mem_waddr        (mem_waddr),
    .wr_ptr_gray      (wr_ptr_gray),
    .rd_ptr_gray_sync (rd_ptr_gray_sync),
    .full             (full),
    .almost_full      (almost_full),
    .level            (level),
    .overflow         (overflow),
    .overflow_clr     (overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] g5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_obs(input string n, input logic rdy, input logic we,
                            input logic [3:0] wa, input logic [4:0] g, input logic fl,
                            input logic af, input logic [4:0] lvl, input logic ov);
    obs_t e;
    e = '{rdy: rdy, we: we, waddr: wa, gray: g, full: fl, af: af, lvl: lvl, ovf: ov};
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // Monitor: compare the queued snapshot against the DUT away from the active edge.
  always @(negedge clk) begin
    obs_t  e;
    obs_t  act;
    string n;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      n   = name_q.pop_front();
      act = {wr_ready, mem_we, mem_waddr, wr_ptr_gray, full, almost_full, level, overflow};
      checks++;
      if (act === e) begin
        passes++;
      end else begin
        $display("FAIL %s @%0t: actual rdy=%b we=%b waddr=%0d gray=%b full=%b af=%b lvl=%0d ovf=%b ; required rdy=%b we=%b waddr=%0d gray=%b full=%b af=%b lvl=%0d ovf=%b",
                 n, $time, act.rdy, act.we, act.waddr, act.gray, act.full, act.af, act.lvl,
                 act.ovf, e.rdy, e.we, e.waddr, e.gray, e.full, e.af, e.lvl, e.ovf);
      end
    end
  end

  initial begin
    int leftover;
    checks           = 0;
    passes           = 0;
    rst_n            = 1'b0;
    wr_valid         = 1'b0;
    overflow_clr     = 1'b0;
    rd_ptr_gray_sync = 5'd0;

    // Reset values.
    step();
    expect_obs("reset", 1, 0, 4'd0, 5'b00000, 0, 0, 5'd0, 0);
    step();
    rst_n = 1'b1;

    // Sixteen back-to-back writes with the reader idle.
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1;
      expect_obs("fill", 1, 1, 4'(i), g5(5'(i)), 0, (i >= 12), 5'(i), 0);
      step();
    end
    wr_valid = 1'b0;
    expect_obs("full", 0, 0, 4'd0, 5'b11000, 1, 1, 5'd16, 0);
    step();

    // Write while full: overflow sets, pointer holds; set beats a coincident clear.
    wr_valid = 1'b1;
    expect_obs("ovf_req", 0, 0, 4'd0, 5'b11000, 1, 1, 5'd16, 0);
    step();
    overflow_clr = 1'b1;
    expect_obs("ovf_set", 0, 0, 4'd0, 5'b11000, 1, 1, 5'd16, 1);
    step();
    wr_valid     = 1'b0;
    overflow_clr = 1'b0;
    expect_obs("ovf_set_wins", 0, 0, 4'd0, 5'b11000, 1, 1, 5'd16, 1);
    step();
    overflow_clr = 1'b1;
    expect_obs("ovf_sticky", 0, 0, 4'd0, 5'b11000, 1, 1, 5'd16, 1);
    step();
    overflow_clr = 1'b0;
    expect_obs("ovf_clr", 0, 0, 4'd0, 5'b11000, 1, 1, 5'd16, 0);
    step();

    // Read pointer advances by one: visible exactly one cycle later.
    rd_ptr_gray_sync = 5'b00001;
    expect_obs("rd_same_cycle", 0, 0, 4'd0, 5'b11000, 1, 1, 5'd16, 0);
    step();
    expect_obs("rd_moved", 1, 0, 4'd0, 5'b11000, 0, 1, 5'd15, 0);
    step();

    // Streaming: write every cycle while the reader trails by eight, through the wrap.
    wb = 5'd16;
    lv = 5'd15;
    for (int k = 0; k < 64; k++) begin
      rb               = wb - 5'd8;
      rd_ptr_gray_sync = g5(rb);
      wr_valid         = 1'b1;
      expect_obs("stream", 1, 1, wb[3:0], g5(wb), 0, (lv >= 5'd12), lv, 0);
      step();
      lv = (wb + 5'd1) - rb;
      wb = wb + 5'd1;
    end
    wr_valid = 1'b0;
    expect_obs("stream_end", 1, 0, wb[3:0], g5(wb), 0, (lv >= 5'd12), lv, 0);
    step();

    // Asynchronous reset takes effect before the next clock edge.
    rst_n            = 1'b0;
    rd_ptr_gray_sync = 5'd0;
    expect_obs("rst_async_1", 1, 0, 4'd0, 5'b00000, 0, 0, 5'd0, 0);
    step();
    rst_n = 1'b1;

    // Seven writes, then a mid-operation reset pulse.
    for (int i = 0; i < 7; i++) begin
      wr_valid = 1'b1;
      expect_obs("post_rst_fill", 1, 1, 4'(i), g5(5'(i)), 0, 0, 5'(i), 0);
      step();
    end
    wr_valid = 1'b0;
    expect_obs("seven", 1, 0, 4'd7, 5'b00100, 0, 0, 5'd7, 0);
    step();
    rst_n = 1'b0;
    expect_obs("rst_async_2", 1, 0, 4'd0, 5'b00000, 0, 0, 5'd0, 0);
    step();
    rst_n    = 1'b1;
    wr_valid = 1'b1;
    expect_obs("first_after_rst", 1, 1, 4'd0, 5'b00000, 0, 0, 5'd0, 0);
    step();
    wr_valid = 1'b0;
    expect_obs("after_one", 1, 0, 4'd1, 5'b00001, 0, 0, 5'd1, 0);
    step();
    step();

    leftover = exp_q.size();
    if (leftover != 0) begin
      $display("FAIL scoreboard_drain: actual %0d unchecked entries, required 0", leftover);
    end
    $display("%0d/%0d checks passed", passes, checks + leftover);
    $finish;
  end

endmodule
